// File: rtl/comp_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : comp_pipe_n
// Description : Registered N-bit magnitude comparator with a valid/ready
//               stream interface. Each accepted operand pair produces one
//               one-hot result y = {gt,eq,lt} after exactly one clock. The
//               result sits in a single output register that holds under
//               backpressure. The compare is unsigned or two's-complement,
//               chosen per transfer by signed_mode.
//               Build option COMP_STATS_EN: when defined, three saturating
//               counters count delivered gt/eq/lt results, and clr_stats
//               clears them. When undefined, no counter flops are built, the
//               counters read 0 and clr_stats is ignored.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, a, b, signed_mode  - operand stream
//               out_valid/out_ready, y                - result stream
//               clr_stats, gt_cnt, eq_cnt, lt_cnt     - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module comp_pipe_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       y,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    logic             r_out_valid;
    logic [2:0]       r_y;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [2:0]       w_y;

    // The output register can take a new pair when it is empty, or when
    // it is being drained on this same edge.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_deliver  = r_out_valid && out_ready;

    // Widen by one bit. The extra bit is a sign copy in signed mode and zero
    // in unsigned mode. One signed compare then covers both modes.
    assign w_a_ext = {signed_mode & a[WIDTH-1], a};
    assign w_b_ext = {signed_mode & b[WIDTH-1], b};

    always_comb begin
        w_y = 3'b000;
        if ($signed(w_a_ext) > $signed(w_b_ext)) begin
            w_y = 3'b100;
        end else if (w_a_ext == w_b_ext) begin
            w_y = 3'b010;
        end else begin
            w_y = 3'b001;
        end
    end

    // On a drain with no new accept, y keeps its last value and only
    // out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= 3'b000;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y;
        end else if (w_deliver) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

`ifdef COMP_STATS_EN
    // Counter index i follows the bit order of y: 0 = lt, 1 = eq, 2 = gt.
    logic [CNT_W-1:0] r_cnt [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[gi] <= '0;
            end else if (clr_stats) begin
                // A clear wins over a handshake on the same edge. That
                // result is dropped, not counted.
                r_cnt[gi] <= '0;
            end else if (w_deliver && r_y[gi] && (r_cnt[gi] != '1)) begin
                r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
            end
        end
    end

    assign lt_cnt = r_cnt[0];
    assign eq_cnt = r_cnt[1];
    assign gt_cnt = r_cnt[2];
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_stats;

    assign lt_cnt = '0;
    assign eq_cnt = '0;
    assign gt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comp_pipe_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_pipe_n
// Description : Self-checking bench for comp_pipe_n (WIDTH=4, CNT_W=2).
//               A reference compare pushes the expected y into a queue when
//               a pair is accepted. The entry is popped and compared when the
//               result is delivered. Handshakes, hold behaviour and
//               statistics counters are tracked by a small model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_pipe_n;

    localparam int c_width = 4;
    localparam int c_cnt_w = 2;
    localparam int c_sat   = (1 << c_cnt_w) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [c_width-1:0] a = '0;
    logic [c_width-1:0] b = '0;
    logic               signed_mode = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2:0]         y;
    logic               clr_stats = 1'b0;
    logic [c_cnt_w-1:0] gt_cnt;
    logic [c_cnt_w-1:0] eq_cnt;
    logic [c_cnt_w-1:0] lt_cnt;

    comp_pipe_n #(.WIDTH(c_width), .CNT_W(c_cnt_w)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .clr_stats   (clr_stats),
        .gt_cnt      (gt_cnt),
        .eq_cnt      (eq_cnt),
        .lt_cnt      (lt_cnt)
    );

    always #5 clk = ~clk;

    int         r_checks = 0;
    int         r_errors = 0;
    logic [2:0] r_q[$];
    logic [2:0] r_last_y = 3'b000;
    int         r_cnt[3] = '{0, 0, 0};
    logic       r_live = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [3:0] ra, input logic [3:0] rb, input logic sm);
        int av;
        int bv;
        av = int'(ra);
        bv = int'(rb);
        if (sm && ra[3]) av = av - 16;
        if (sm && rb[3]) bv = bv - 16;
        if (av > bv)       return 3'b100;
        else if (av == bv) return 3'b010;
        else               return 3'b001;
    endfunction

    // One clock cycle. At the falling edge, check the outputs against the
    // model. Then apply the handshakes the next rising edge will perform.
    task automatic step();
        logic       acc;
        logic       del;
        logic [2:0] exp_y;
        @(negedge clk);
        if (r_live) begin
            check_val("out_valid", 32'(out_valid), 32'(r_q.size() != 0));
            check_val("in_ready", 32'(in_ready), 32'((r_q.size() == 0) || out_ready));
            check_val("y_hold", 32'(y), 32'(r_last_y));
`ifdef COMP_STATS_EN
            check_val("gt_cnt", 32'(gt_cnt), 32'(r_cnt[2]));
            check_val("eq_cnt", 32'(eq_cnt), 32'(r_cnt[1]));
            check_val("lt_cnt", 32'(lt_cnt), 32'(r_cnt[0]));
`else
            check_val("gt_cnt", 32'(gt_cnt), 32'd0);
            check_val("eq_cnt", 32'(eq_cnt), 32'd0);
            check_val("lt_cnt", 32'(lt_cnt), 32'd0);
`endif
        end
        if (!rst_n) begin
            r_q.delete();
            r_last_y = 3'b000;
            r_cnt    = '{0, 0, 0};
            r_live   = 1'b1;
        end else begin
            acc = in_valid && ((r_q.size() == 0) || out_ready);
            del = (r_q.size() != 0) && out_ready;
            if (del) begin
                exp_y = r_q.pop_front();
                check_val("y_result", 32'(y), 32'(exp_y));
                for (int i = 0; i < 3; i++)
                    if (exp_y[i] && r_cnt[i] < c_sat) r_cnt[i]++;
            end
            if (clr_stats) r_cnt = '{0, 0, 0};
            if (acc) begin
                exp_y = ref_cmp(a, b, signed_mode);
                r_q.push_back(exp_y);
                r_last_y = exp_y;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic sm);
        in_valid    = 1'b1;
        a           = ta;
        b           = tb;
        signed_mode = sm;
        step();
        in_valid    = 1'b0;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed compares with out_ready held high
        send(4'hF, 4'hF, 1'b0);
        send(4'h9, 4'h6, 1'b0);
        send(4'h9, 4'h6, 1'b1);
        send(4'h8, 4'h7, 1'b1);
        send(4'h3, 4'h4, 1'b0);
        send(4'h7, 4'h8, 1'b1);
        send(4'h8, 4'h0, 1'b1);
        step();
        step();

        // Backpressure: pair held valid while downstream stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 4'h1; b = 4'h2; signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        a = 4'hA; b = 4'h2; signed_mode = 1'b1;
        step();
        a = 4'hA; b = 4'h2; signed_mode = 1'b0;
        step();
        a = 4'h5; b = 4'h5; signed_mode = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();

        // Counter saturation on eq, then a clear that coincides with a handshake
        for (int i = 0; i < 5; i++) send(4'h6, 4'h6, 1'(i & 1));
        step();
        send(4'h5, 4'h5, 1'b0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            a           = 4'($urandom_range(0, 15));
            b           = 4'($urandom_range(0, 15));
            signed_mode = 1'($urandom_range(0, 1));
            clr_stats   = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid  = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset while a result is held under backpressure
        send(4'h2, 4'h9, 1'b0);
        send(4'h2, 4'h9, 1'b0);
        out_ready = 1'b0;
        send(4'hC, 4'h3, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send(4'h4, 4'h3, 1'b1);
        step();

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
